// File: rtl/multicycle_ctrl.sv
// Multicycle ARM sequencing controller: Moore FSM, NZCV flags register and condition check.
// Optional retire counter (RetireCount) is built when MULTICYCLE_CTRL_PERF_EN is defined.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  ALUControl,
    output logic        Undef
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] RetireCount
`endif
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_EOR = 4'b0100;
    localparam logic [3:0] ALU_MOV = 4'b0101;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_flags;

    logic [1:0] w_op;
    logic       w_i;
    logic [3:0] w_cmd;
    logic       w_s;
    logic       w_rd15;
    logic       w_u;
    logic       w_l;
    logic       w_bl;
    logic       w_cmd_ok;
    logic       w_is_cmp;
    logic       w_is_logic;
    logic [3:0] w_dp_alu;
    logic       w_undef;
    logic       w_cond;
    logic       w_unused;

    assign w_op     = Instr[27:26];
    assign w_i      = Instr[25];
    assign w_cmd    = Instr[24:21];
    assign w_s      = Instr[20];
    assign w_rd15   = (Instr[15:12] == 4'hF);
    assign w_u      = Instr[23];
    assign w_l      = Instr[20];
    assign w_bl     = Instr[24];
    assign w_unused = ^{Instr[19:16], Instr[11:5], Instr[3:0], w_bl};

    assign ImmSrc = w_op;
    assign RegSrc = {(w_op == 2'b01) && !w_l, (w_op == 2'b10)};

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !c || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    assign w_cond = cond_pass(Instr[31:28], r_flags);

    always_comb begin
        w_cmd_ok   = 1'b1;
        w_is_cmp   = 1'b0;
        w_is_logic = 1'b0;
        w_dp_alu   = ALU_ADD;
        case (w_cmd)
            4'b0100: w_dp_alu = ALU_ADD;
            4'b0010: w_dp_alu = ALU_SUB;
            4'b1010: begin w_dp_alu = ALU_SUB; w_is_cmp = 1'b1; end
            4'b0000: begin w_dp_alu = ALU_AND; w_is_logic = 1'b1; end
            4'b1100: begin w_dp_alu = ALU_ORR; w_is_logic = 1'b1; end
            4'b0001: begin w_dp_alu = ALU_EOR; w_is_logic = 1'b1; end
            4'b1101: begin w_dp_alu = ALU_MOV; w_is_logic = 1'b1; end
            default: w_cmd_ok = 1'b0;
        endcase
    end

    // Memory ops reject byte access, post-indexing and writeback (bits 22, 24, 21).
    assign w_undef = (w_op == 2'b11)
                   || ((w_op == 2'b00) && ((!w_i && Instr[4]) || !w_cmd_ok))
                   || ((w_op == 2'b01) && (Instr[22] || !Instr[24] || Instr[21]));

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (!w_cond || w_undef) w_next = S_FETCH;
                else begin
                    case (w_op)
                        2'b01:   w_next = S_MEMADR;
                        2'b00:   w_next = w_i ? S_EXECI : S_EXECR;
                        2'b10:   w_next = S_BRANCH;
                        default: w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: w_next = w_l ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXECR,
            S_EXECI:  w_next = w_is_cmp ? S_FETCH : S_ALUWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_next;
            // Logical ops and MOV have no meaningful C/V, so those bits are kept.
            if (((r_state == S_EXECR) || (r_state == S_EXECI)) && (w_s || w_is_cmp)) begin
                r_flags[3:2] <= ALUFlags[3:2];
                if (!w_is_logic) r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        Undef      = 1'b0;
        if (!reset) begin
            ResultSrc = 2'b10;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
        end else begin
            case (r_state)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_DECODE: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    Undef     = w_undef;
                end
                S_MEMADR: begin
                    ALUSrcB    = 2'b01;
                    ALUControl = w_u ? ALU_ADD : ALU_SUB;
                end
                S_MEMRD:  AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                    PCWrite   = w_rd15;
                end
                S_MEMWR: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR:  ALUControl = w_dp_alu;
                S_EXECI: begin
                    ALUSrcB    = 2'b01;
                    ALUControl = w_dp_alu;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    PCWrite  = w_rd15;
                end
                S_BRANCH: begin
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    PCWrite   = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] r_retire;

    // A return to FETCH from anywhere but DECODE means an instruction completed.
    always_ff @(posedge clk) begin
        if (!reset) r_retire <= 32'd0;
        else if ((w_next == S_FETCH) && (r_state != S_DECODE)) r_retire <= r_retire + 32'd1;
    end

    assign RetireCount = r_retire;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instruction sequences cycle by cycle
// against a hand-written per-state table of expected control outputs.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, Undef;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0]  ALUControl;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] RetireCount;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [3:0] T_FETCH  = 4'd0,  T_DECODE = 4'd1,  T_MEMADR = 4'd2,
                           T_MEMRD  = 4'd3,  T_MEMWB  = 4'd4,  T_MEMWR  = 4'd5,
                           T_EXECR  = 4'd6,  T_EXECI  = 4'd7,  T_ALUWB  = 4'd8,
                           T_BRANCH = 4'd9,  T_UNDEF  = 4'd10, T_RESET  = 4'd11;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .Undef      (Undef)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .RetireCount(RetireCount)
`endif
    );

    always #5 clk = ~clk;

    logic [14:0] w_ctl;
    assign w_ctl = {PCWrite, IRWrite, RegWrite, MemWrite, Undef, AdrSrc,
                    ResultSrc, ALUSrcA, ALUSrcB, ALUControl};

    function automatic logic [14:0] ctl(input logic pcw, input logic irw, input logic rw,
                                        input logic mw, input logic und, input logic adr,
                                        input logic [1:0] res, input logic a,
                                        input logic [1:0] b, input logic [3:0] alu);
        return {pcw, irw, rw, mw, und, adr, res, a, b, alu};
    endfunction

    function automatic logic [19:0] mkseq(input logic [3:0] s0, input logic [3:0] s1,
                                          input logic [3:0] s2, input logic [3:0] s3,
                                          input logic [3:0] s4);
        return {s4, s3, s2, s1, s0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Masks cover all enables plus only the mux fields each state defines.
    task automatic exp_state(input string tag, input logic [3:0] st, input logic [3:0] alu,
                             input logic pcw);
        logic [14:0] v, m;
        v = '0;
        m = '0;
        case (st)
            T_RESET:  begin v = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b10,4'h0); m = 15'h7FFF; end
            T_FETCH:  begin v = ctl(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b10,4'h0); m = 15'h7FFF; end
            T_DECODE: begin v = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b10,4'h0); m = 15'h7DFF; end
            T_UNDEF:  begin v = ctl(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,1'b1,2'b10,4'h0); m = 15'h7DFF; end
            T_MEMADR: begin v = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,alu);  m = 15'h7C7F; end
            T_MEMRD:  begin v = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,4'h0); m = 15'h7F80; end
            T_MEMWB:  begin v = ctl(pcw, 1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,4'h0); m = 15'h7D80; end
            T_MEMWR:  begin v = ctl(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,1'b0,2'b00,4'h0); m = 15'h7F80; end
            T_EXECR:  begin v = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,alu);  m = 15'h7C7F; end
            T_EXECI:  begin v = ctl(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,alu);  m = 15'h7C7F; end
            T_ALUWB:  begin v = ctl(pcw, 1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,4'h0); m = 15'h7D80; end
            T_BRANCH: begin v = ctl(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,2'b01,4'h0); m = 15'h7DFF; end
            default:  begin v = '0; m = 15'h7FFF; end
        endcase
        check(tag, {17'b0, w_ctl & m}, {17'b0, v & m});
    endtask

    // One instruction, starting at its FETCH cycle; ALUFlags carries junk outside EXEC.
    task automatic run(input string tag, input logic [31:0] ins, input logic [3:0] fl,
                       input int n, input logic [19:0] seq, input logic [3:0] alu,
                       input logic pcw, input logic [1:0] imm, input logic [1:0] rsrc);
        logic [3:0] st;
        for (int k = 0; k < n; k++) begin
            st = seq[k*4 +: 4];
            @(posedge clk); #1;
            if (k == 0) begin
                reset = 1'b1;
                Instr = ins;
            end
            ALUFlags = ((st == T_EXECR) || (st == T_EXECI)) ? fl : 4'hF;
            #2;
            exp_state($sformatf("%s_c%0d", tag, k), st, alu, pcw);
            if (k == 1) begin
                check({tag, "_imm"},  {30'b0, ImmSrc}, {30'b0, imm});
                check({tag, "_rsrc"}, {30'b0, RegSrc}, {30'b0, rsrc});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        Instr    = 32'h0;
        ALUFlags = 4'h0;
        repeat (3) begin
            @(posedge clk); #3;
            exp_state("reset", T_RESET, 4'h0, 1'b0);
        end

        run("addeq_f0",  32'h00821001, 4'h0, 2, mkseq(T_FETCH,T_DECODE,0,0,0), 4'h0, 1'b0, 2'b00, 2'b00);
        run("adds",      32'hE2921005, 4'h0, 4, mkseq(T_FETCH,T_DECODE,T_EXECI,T_ALUWB,0), 4'h0, 1'b0, 2'b00, 2'b00);
        run("addeq_f1",  32'h00821001, 4'h0, 2, mkseq(T_FETCH,T_DECODE,0,0,0), 4'h0, 1'b0, 2'b00, 2'b00);
        run("cmp",       32'hE3510000, 4'h4, 3, mkseq(T_FETCH,T_DECODE,T_EXECI,0,0), 4'h1, 1'b0, 2'b00, 2'b00);
        run("addeq_ok",  32'h00821001, 4'hB, 4, mkseq(T_FETCH,T_DECODE,T_EXECR,T_ALUWB,0), 4'h0, 1'b0, 2'b00, 2'b00);
        run("addne",     32'h10821001, 4'h0, 2, mkseq(T_FETCH,T_DECODE,0,0,0), 4'h0, 1'b0, 2'b00, 2'b00);
        run("ldr",       32'hE5110008, 4'h0, 5, mkseq(T_FETCH,T_DECODE,T_MEMADR,T_MEMRD,T_MEMWB), 4'h1, 1'b0, 2'b01, 2'b00);
        run("str",       32'hE5810004, 4'h0, 4, mkseq(T_FETCH,T_DECODE,T_MEMADR,T_MEMWR,0), 4'h0, 1'b0, 2'b01, 2'b10);
        run("undef_op3", 32'hEC000000, 4'h0, 2, mkseq(T_FETCH,T_UNDEF,0,0,0), 4'h0, 1'b0, 2'b11, 2'b00);
        run("undef_rsr", 32'hE0821311, 4'h0, 2, mkseq(T_FETCH,T_UNDEF,0,0,0), 4'h0, 1'b0, 2'b00, 2'b00);
        run("branch",    32'hEA000002, 4'h0, 3, mkseq(T_FETCH,T_DECODE,T_BRANCH,0,0), 4'h0, 1'b0, 2'b10, 2'b01);
        run("cond_nv",   32'hF0821001, 4'h0, 2, mkseq(T_FETCH,T_DECODE,0,0,0), 4'h0, 1'b0, 2'b00, 2'b00);
        run("adds_cv",   32'hE2921005, 4'h3, 4, mkseq(T_FETCH,T_DECODE,T_EXECI,T_ALUWB,0), 4'h0, 1'b0, 2'b00, 2'b00);
        run("movs",      32'hE3B00000, 4'hC, 4, mkseq(T_FETCH,T_DECODE,T_EXECI,T_ALUWB,0), 4'h5, 1'b0, 2'b00, 2'b00);
        run("addcs",     32'h20821001, 4'h0, 4, mkseq(T_FETCH,T_DECODE,T_EXECR,T_ALUWB,0), 4'h0, 1'b0, 2'b00, 2'b00);
        run("addvs",     32'h60821001, 4'h0, 4, mkseq(T_FETCH,T_DECODE,T_EXECR,T_ALUWB,0), 4'h0, 1'b0, 2'b00, 2'b00);
        run("addhi",     32'h80821001, 4'h0, 2, mkseq(T_FETCH,T_DECODE,0,0,0), 4'h0, 1'b0, 2'b00, 2'b00);
        run("add_pc",    32'hE282F000, 4'h0, 4, mkseq(T_FETCH,T_DECODE,T_EXECI,T_ALUWB,0), 4'h0, 1'b1, 2'b00, 2'b00);

        run("abort",     32'hE0821001, 4'h0, 3, mkseq(T_FETCH,T_DECODE,T_EXECR,0,0), 4'h0, 1'b0, 2'b00, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0;
        #2;
        exp_state("midrst", T_RESET, 4'h0, 1'b0);

        run("addeq_rst", 32'h00821001, 4'h0, 2, mkseq(T_FETCH,T_DECODE,0,0,0), 4'h0, 1'b0, 2'b00, 2'b00);
        run("add_r",     32'hE0821001, 4'h0, 4, mkseq(T_FETCH,T_DECODE,T_EXECR,T_ALUWB,0), 4'h0, 1'b0, 2'b00, 2'b00);
        run("add_i",     32'hE2821005, 4'h0, 4, mkseq(T_FETCH,T_DECODE,T_EXECI,T_ALUWB,0), 4'h0, 1'b0, 2'b00, 2'b00);
        run("addeq_f2",  32'h00821001, 4'h0, 2, mkseq(T_FETCH,T_DECODE,0,0,0), 4'h0, 1'b0, 2'b00, 2'b00);
        run("str2",      32'hE5810004, 4'h0, 4, mkseq(T_FETCH,T_DECODE,T_MEMADR,T_MEMWR,0), 4'h0, 1'b0, 2'b01, 2'b10);

        @(posedge clk); #3;
        exp_state("end_fetch", T_FETCH, 4'h0, 1'b0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("retire", RetireCount, 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
